// File: rtl/draw_lines_pkg.sv
// rtl/draw_lines_pkg.sv - shared types, widths and helpers for the multi-line rasteriser
// line_t   : one segment {x1, y1, x2, y2}
// slot_t   : one table entry {line, RGB888 colour, enable}
package draw_lines_pkg;

    localparam int COORD_XW = 11;
    localparam int COORD_YW = 10;
    localparam int PROD_W   = 23;
    localparam int PIPE_LAT = 3;
    localparam logic [23:0] MARKER_COLOR = 24'hFF_00_00;

    typedef struct packed {
        logic [COORD_XW-1:0] x1;
        logic [COORD_YW-1:0] y1;
        logic [COORD_XW-1:0] x2;
        logic [COORD_YW-1:0] y2;
    } line_t;

    typedef struct packed {
        line_t       line;
        logic [23:0] color;
        logic        en;
    } slot_t;

    typedef enum logic {
        CS_IDLE    = 1'b0,
        CS_PENDING = 1'b1
    } commit_state_t;

    // Stored lines always have x1 <= x2, so the x part of the bbox needs no min/max.
    function automatic line_t normalize_line(input line_t l);
        line_t r;
        r = l;
        if (l.x1 > l.x2) begin
            r.x1 = l.x2;
            r.y1 = l.y2;
            r.x2 = l.x1;
            r.y2 = l.y1;
        end
        return r;
    endfunction

    // Chebyshev distance <= 2 between pixel (h, v) and point (x, y).
    function automatic logic near_point(input logic [COORD_XW-1:0] h, input logic [COORD_YW-1:0] v,
                                        input logic [COORD_XW-1:0] x, input logic [COORD_YW-1:0] y);
        return ({1'b0, h} + 12'd2 >= {1'b0, x}) && ({1'b0, h} <= {1'b0, x} + 12'd2) &&
               ({1'b0, v} + 11'd2 >= {1'b0, y}) && ({1'b0, v} <= {1'b0, y} + 11'd2);
    endfunction

endpackage

// File: rtl/line_hit_eval.sv
// rtl/line_hit_eval.sv - per-slot S1/S2 arithmetic: bbox and cross-product distance test
// clk_in, rst_in (sync, active-low); hcount_in/vcount_in pixel; line_in/en_in slot from active table
// bbox_ok_out : enabled and pixel inside segment bbox (registered, end of S2)
// near_ok_out : |dyp*dxl - dxp*dyl| <= TOL (registered, end of S2)
// mark_ok_out : enabled and pixel within 2 of an endpoint (only with DRAW_LINES_MULTI_MARKER_EN)
module line_hit_eval
    import draw_lines_pkg::*;
#(
    parameter int TOL = 500
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [COORD_XW-1:0] hcount_in,
    input  logic [COORD_YW-1:0] vcount_in,
    input  line_t               line_in,
    input  logic                en_in,
    output logic                bbox_ok_out,
    output logic                near_ok_out
`ifdef DRAW_LINES_MULTI_MARKER_EN
    ,
    output logic                mark_ok_out
`endif
);

    localparam int DW = PROD_W + 1;

    logic signed [COORD_XW:0] dxp_q, dxl_q;
    logic signed [COORD_YW:0] dyp_q, dyl_q;
    logic                     bbox_q;
    logic [COORD_YW-1:0]      y_lo, y_hi;
    logic                     bbox_c;
    logic signed [PROD_W-1:0] p1, p2;
    logic signed [DW-1:0]     d;
    logic [DW-1:0]            d_abs;
    logic                     near_c;

    // The enable is folded into the S1 flag so in-flight pixels keep the table they started with.
    always_comb begin
        y_lo   = (line_in.y1 < line_in.y2) ? line_in.y1 : line_in.y2;
        y_hi   = (line_in.y1 < line_in.y2) ? line_in.y2 : line_in.y1;
        bbox_c = en_in && (hcount_in >= line_in.x1) && (hcount_in <= line_in.x2) &&
                 (vcount_in >= y_lo) && (vcount_in <= y_hi);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            dxp_q  <= '0;
            dyp_q  <= '0;
            dxl_q  <= '0;
            dyl_q  <= '0;
            bbox_q <= 1'b0;
        end else begin
            dxp_q  <= {1'b0, hcount_in} - {1'b0, line_in.x1};
            dyp_q  <= {1'b0, vcount_in} - {1'b0, line_in.y1};
            dxl_q  <= {1'b0, line_in.x2} - {1'b0, line_in.x1};
            dyl_q  <= {1'b0, line_in.y2} - {1'b0, line_in.y1};
            bbox_q <= bbox_c;
        end
    end

    always_comb begin
        p1     = PROD_W'(dyp_q) * PROD_W'(dxl_q);
        p2     = PROD_W'(dxp_q) * PROD_W'(dyl_q);
        d      = DW'(p1) - DW'(p2);
        d_abs  = d[DW-1] ? DW'(-d) : DW'(d);
        near_c = (d_abs <= DW'(TOL));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bbox_ok_out <= 1'b0;
            near_ok_out <= 1'b0;
        end else begin
            bbox_ok_out <= bbox_q;
            near_ok_out <= near_c;
        end
    end

`ifdef DRAW_LINES_MULTI_MARKER_EN
    logic mark_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mark_q      <= 1'b0;
            mark_ok_out <= 1'b0;
        end else begin
            mark_q      <= en_in && (near_point(hcount_in, vcount_in, line_in.x1, line_in.y1) ||
                                     near_point(hcount_in, vcount_in, line_in.x2, line_in.y2));
            mark_ok_out <= mark_q;
        end
    end
`endif

endmodule

// File: rtl/draw_lines_multi.sv
// rtl/draw_lines_multi.sv - pipelined multi-line rasteriser with double-buffered line table
// clk_in, rst_in (sync, active-low); hcount_in/vcount_in pixel position
// wr_valid_in/wr_ready_out/wr_idx_in/wr_line_in/wr_color_in/wr_en_in : shadow table write
// commit_in : request shadow->active swap at (0, V_ACTIVE); swap_out pulses on that cycle
// hit_out/hit_idx_out/red_out/green_out/blue_out : result for pixel presented 3 cycles earlier
// Optional endpoint marker: define DRAW_LINES_MULTI_MARKER_EN
module draw_lines_multi
    import draw_lines_pkg::*;
#(
    parameter int          NUM_LINES = 8,
    parameter int          TOL       = 500,
    parameter int          V_ACTIVE  = 720,
    parameter logic [23:0] BG_COLOR  = 24'h0,
    localparam int         IDXW      = $clog2(NUM_LINES)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [COORD_XW-1:0] hcount_in,
    input  logic [COORD_YW-1:0] vcount_in,
    input  logic                wr_valid_in,
    output logic                wr_ready_out,
    input  logic [IDXW-1:0]     wr_idx_in,
    input  logic [41:0]         wr_line_in,
    input  logic [23:0]         wr_color_in,
    input  logic                wr_en_in,
    input  logic                commit_in,
    output logic                swap_out,
    output logic                hit_out,
    output logic [IDXW-1:0]     hit_idx_out,
    output logic [7:0]          red_out,
    output logic [7:0]          green_out,
    output logic [7:0]          blue_out
);

    commit_state_t state_q, state_d;
    logic          swap_pt;
    logic          wr_fire;

    assign swap_pt = (hcount_in == '0) && (vcount_in == COORD_YW'(V_ACTIVE));
    assign wr_fire = wr_valid_in && wr_ready_out;

    always_ff @(posedge clk_in) begin
        if (!rst_in) state_q <= CS_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CS_IDLE:    if (commit_in) state_d = CS_PENDING;
            CS_PENDING: if (swap_pt)   state_d = CS_IDLE;
            default:    state_d = CS_IDLE;
        endcase
    end

    always_comb begin
        wr_ready_out = (state_q == CS_IDLE);
        swap_out     = (state_q == CS_PENDING) && swap_pt;
    end

    slot_t       shadow_tbl [NUM_LINES];
    slot_t       active_tbl [NUM_LINES];
    // Colours of the table replaced by the last swap, for the two pixels still past S1.
    logic [23:0] old_color  [NUM_LINES];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                shadow_tbl[i] <= '0;
                active_tbl[i] <= '0;
                old_color[i]  <= '0;
            end
        end else begin
            if (wr_fire)
                shadow_tbl[wr_idx_in] <= {normalize_line(line_t'(wr_line_in)), wr_color_in, wr_en_in};
            if (swap_out) begin
                for (int i = 0; i < NUM_LINES; i++) begin
                    active_tbl[i] <= shadow_tbl[i];
                    old_color[i]  <= active_tbl[i].color;
                end
            end
        end
    end

    logic [PIPE_LAT-2:0] valid_q;
    logic [1:0]          stale_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q <= '0;
            stale_q <= '0;
        end else begin
            valid_q <= {valid_q[PIPE_LAT-3:0], 1'b1};
            stale_q <= {stale_q[0], swap_out};
        end
    end

    logic [NUM_LINES-1:0] bbox_ok, near_ok;
`ifdef DRAW_LINES_MULTI_MARKER_EN
    logic [NUM_LINES-1:0] mark_ok;
`endif

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_slot
        line_hit_eval #(.TOL(TOL)) u_eval (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .hcount_in   (hcount_in),
            .vcount_in   (vcount_in),
            .line_in     (active_tbl[g].line),
            .en_in       (active_tbl[g].en),
            .bbox_ok_out (bbox_ok[g]),
            .near_ok_out (near_ok[g])
`ifdef DRAW_LINES_MULTI_MARKER_EN
            ,
            .mark_ok_out (mark_ok[g])
`endif
        );
    end

    logic            hit_c;
    logic [IDXW-1:0] idx_c;
    logic [23:0]     color_c;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_c   = 1'b0;
        idx_c   = '0;
        color_c = BG_COLOR;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (bbox_ok[i] && near_ok[i]) begin
                hit_c   = 1'b1;
                idx_c   = IDXW'(i);
                color_c = (|stale_q) ? old_color[i] : active_tbl[i].color;
            end
        end
`ifdef DRAW_LINES_MULTI_MARKER_EN
        if (|mark_ok) begin
            hit_c   = 1'b1;
            color_c = MARKER_COLOR;
            for (int i = NUM_LINES - 1; i >= 0; i--) begin
                if (mark_ok[i]) idx_c = IDXW'(i);
            end
        end
`endif
    end

    logic [23:0] color_q;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hit_out     <= 1'b0;
            hit_idx_out <= '0;
            color_q     <= BG_COLOR;
        end else begin
            hit_out     <= valid_q[PIPE_LAT-2] && hit_c;
            hit_idx_out <= (valid_q[PIPE_LAT-2] && hit_c) ? idx_c : '0;
            color_q     <= valid_q[PIPE_LAT-2] ? color_c : BG_COLOR;
        end
    end

    assign {red_out, green_out, blue_out} = color_q;

endmodule

// File: tb/tb_draw_lines_multi.sv
// tb/tb_draw_lines_multi.sv - self-checking bench for draw_lines_multi against a table model
module tb_draw_lines_multi;

    localparam int NL    = 8;
    localparam int TOL   = 500;
    localparam int V_ACT = 720;
    localparam int IDLE_H = 2000;
    localparam int IDLE_V = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_idx = '0;
    logic [41:0] wr_line = '0;
    logic [23:0] wr_color = '0;
    logic        wr_en = 1'b0;
    logic        commit = 1'b0;
    logic        swap;
    logic        hit;
    logic [2:0]  hit_idx;
    logic [7:0]  red, green, blue;

    draw_lines_multi #(.NUM_LINES(NL), .TOL(TOL), .V_ACTIVE(V_ACT), .BG_COLOR(24'h0)) dut (
        .clk_in(clk), .rst_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .wr_valid_in(wr_valid), .wr_ready_out(wr_ready), .wr_idx_in(wr_idx),
        .wr_line_in(wr_line), .wr_color_in(wr_color), .wr_en_in(wr_en),
        .commit_in(commit), .swap_out(swap), .hit_out(hit), .hit_idx_out(hit_idx),
        .red_out(red), .green_out(green), .blue_out(blue)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h; int v; bit hit; int idx; int col;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int sx1[NL], sy1[NL], sx2[NL], sy2[NL], scol[NL];
    bit sen[NL];
    int ax1[NL], ay1[NL], ax2[NL], ay2[NL], acol[NL];
    bit aen[NL];
    bit pend;

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) begin
            sx1[i] = 0; sy1[i] = 0; sx2[i] = 0; sy2[i] = 0; scol[i] = 0; sen[i] = 0;
            ax1[i] = 0; ay1[i] = 0; ax2[i] = 0; ay2[i] = 0; acol[i] = 0; aen[i] = 0;
        end
        pend = 0;
    endfunction

    // A pixel is drawn by slot i when inside the segment's box and close to its supporting line.
    function automatic void model_pix(input int h, input int v, output bit mh, output int mi, output int mc);
        int ylo, yhi, d;
        mh = 0; mi = 0; mc = 0;
        for (int i = 0; i < NL && !mh; i++) begin
            ylo = (ay1[i] < ay2[i]) ? ay1[i] : ay2[i];
            yhi = (ay1[i] < ay2[i]) ? ay2[i] : ay1[i];
            d = (v - ay1[i]) * (ax2[i] - ax1[i]) - (h - ax1[i]) * (ay2[i] - ay1[i]);
            if (aen[i] && h >= ax1[i] && h <= ax2[i] && v >= ylo && v <= yhi && iabs(d) <= TOL) begin
                mh = 1; mi = i; mc = acol[i];
            end
        end
`ifdef DRAW_LINES_MULTI_MARKER_EN
        for (int i = 0; i < NL; i++) begin
            if (aen[i] && ((iabs(h - ax1[i]) <= 2 && iabs(v - ay1[i]) <= 2) ||
                           (iabs(h - ax2[i]) <= 2 && iabs(v - ay2[i]) <= 2))) begin
                mh = 1; mi = i; mc = 24'hFF0000;
                break;
            end
        end
`endif
    endfunction

    // One clock: check the pixel from 3 cycles back, drive this cycle, advance the model.
    task automatic step(input int h, input int v, input bit wv, input int widx,
                        input int lx1, input int ly1, input int lx2, input int ly2,
                        input int lcol, input bit len, input bit cmt);
        exp_t e;
        bit   swp;
        logic [23:0] rgb;
        if (q.size() == 3) begin
            e = q.pop_front();
            rgb = {red, green, blue};
            n_checks++;
            if (hit !== e.hit || hit_idx !== 3'(e.idx) || rgb !== 24'(e.col)) begin
                n_fail++;
                $display("FAIL pixel (%0d,%0d): got hit=%0b idx=%0d rgb=%06h, expected hit=%0b idx=%0d rgb=%06h",
                         e.h, e.v, hit, hit_idx, rgb, e.hit, e.idx, 24'(e.col));
            end
        end
        hcount   = h[10:0];
        vcount   = v[9:0];
        wr_valid = wv;
        wr_idx   = widx[2:0];
        wr_line  = {lx1[10:0], ly1[9:0], lx2[10:0], ly2[9:0]};
        wr_color = lcol[23:0];
        wr_en    = len;
        commit   = cmt;
        #1;
        swp = pend && h == 0 && v == V_ACT;
        n_checks++;
        if (swap !== swp) begin
            n_fail++;
            $display("FAIL swap_out at (%0d,%0d): got %0b expected %0b", h, v, swap, swp);
        end
        n_checks++;
        if (wr_ready !== !pend) begin
            n_fail++;
            $display("FAIL wr_ready_out at (%0d,%0d): got %0b expected %0b", h, v, wr_ready, !pend);
        end
        e.h = h; e.v = v;
        model_pix(h, v, e.hit, e.idx, e.col);
        q.push_back(e);
        if (wv && !pend) begin
            if (lx1 > lx2) begin
                sx1[widx] = lx2; sy1[widx] = ly2; sx2[widx] = lx1; sy2[widx] = ly1;
            end else begin
                sx1[widx] = lx1; sy1[widx] = ly1; sx2[widx] = lx2; sy2[widx] = ly2;
            end
            scol[widx] = lcol;
            sen[widx]  = len;
        end
        if (pend) begin
            if (swp) begin
                ax1 = sx1; ay1 = sy1; ax2 = sx2; ay2 = sy2; acol = scol; aen = sen;
                pend = 0;
            end
        end else if (cmt) begin
            pend = 1;
        end
        @(negedge clk);
    endtask

    task automatic pix(input int h, input int v);
        step(h, v, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int idx, input int x1, input int y1, input int x2, input int y2,
                      input int col, input bit en);
        step(IDLE_H, IDLE_V, 1, idx, x1, y1, x2, y2, col, en, 0);
    endtask

    task automatic do_commit();
        step(IDLE_H, IDLE_V, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic swap_frame();
        pix(5, V_ACT - 1);
        pix(0, V_ACT);
        pix(1, V_ACT);
    endtask

    task automatic drain();
        repeat (3) pix(IDLE_H, IDLE_V);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0;
        commit = 1'b0;
        hcount = IDLE_H[10:0];
        vcount = IDLE_V[9:0];
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL reset hit_out: got %0b expected 0", hit); end
        n_checks++;
        if (hit_idx !== 3'd0) begin n_fail++; $display("FAIL reset hit_idx_out: got %0d expected 0", hit_idx); end
        n_checks++;
        if ({red, green, blue} !== 24'h0) begin n_fail++; $display("FAIL reset rgb: got %06h expected 000000", {red, green, blue}); end
        n_checks++;
        if (swap !== 1'b0) begin n_fail++; $display("FAIL reset swap_out: got %0b expected 0", swap); end
        n_checks++;
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset wr_ready_out: got %0b expected 1", wr_ready); end
        q.delete();
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic test_no_commit();
        wr(0, 0, 0, 100, 100, 24'h123456, 1);
        for (int y = 0; y < 12; y++)
            for (int x = 0; x < 12; x++)
                pix(x * 9, y * 9);
        swap_frame();
        drain();
    endtask

    task automatic test_single_line();
        wr(0, 10, 10, 100, 55, 24'hE01010, 1);
        do_commit();
        swap_frame();
        pix(54, 32);
        pix(101, 55);
        pix(54, 200);
        pix(10, 10);
        pix(100, 55);
        pix(9, 10);
        drain();
    endtask

    task automatic test_vertical();
        wr(1, 50, 80, 50, 20, 24'h10E010, 1);
        do_commit();
        swap_frame();
        for (int y = 18; y <= 82; y += 2) pix(50, y);
        pix(50, 81);
        pix(50, 19);
        pix(49, 40);
        pix(51, 40);
        drain();
    endtask

    task automatic test_priority();
        wr(0, 20, 20, 100, 100, 24'hA0A000, 1);
        wr(3, 100, 20, 20, 100, 24'h00A0A0, 1);
        do_commit();
        swap_frame();
        pix(60, 60);
        pix(30, 90);
        pix(30, 30);
        wr(0, 20, 20, 100, 100, 24'hA0A000, 0);
        do_commit();
        swap_frame();
        pix(60, 60);
        drain();
    endtask

    task automatic test_commit_block();
        wr(2, 0, 120, 120, 120, 24'h0000C0, 1);
        do_commit();
        wr(2, 0, 130, 120, 130, 24'hC0C0C0, 1);
        do_commit();
        swap_frame();
        pix(60, 120);
        pix(60, 130);
        wr(2, 0, 130, 120, 130, 24'hC0C0C0, 1);
        step(0, V_ACT, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        pix(60, 130);
        swap_frame();
        pix(60, 130);
        pix(60, 120);
        do_commit();
        pix(3, 3);
        test_reset();
        swap_frame();
        pix(60, 130);
        drain();
    endtask

    task automatic test_marker();
        wr(0, 10, 10, 100, 55, 24'h2020F0, 1);
        do_commit();
        swap_frame();
        pix(12, 8);
        pix(8, 12);
        pix(13, 10);
        pix(102, 57);
        pix(30, 20);
        drain();
    endtask

    task automatic test_random();
        int s, h, v, ylo, yhi;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NL; i++)
                wr(i, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
                   $urandom_range(0, 127), int'($urandom_range(0, 24'hFFFFFF)), $urandom_range(0, 3) != 0);
            do_commit();
            swap_frame();
            for (int k = 0; k < 300; k++) begin
                s = $urandom_range(0, NL - 1);
                if ($urandom_range(0, 1) == 1 && aen[s]) begin
                    h = $urandom_range(ax1[s], ax2[s]);
                    if (ax2[s] == ax1[s]) begin
                        ylo = (ay1[s] < ay2[s]) ? ay1[s] : ay2[s];
                        yhi = (ay1[s] < ay2[s]) ? ay2[s] : ay1[s];
                        v = $urandom_range(ylo, yhi);
                    end else begin
                        v = ay1[s] + ((h - ax1[s]) * (ay2[s] - ay1[s])) / (ax2[s] - ax1[s]);
                    end
                end else begin
                    h = $urandom_range(0, 130);
                    v = $urandom_range(0, 130);
                end
                pix(h, v);
            end
            drain();
        end
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        test_reset();
        test_no_commit();
        test_single_line();
        test_vertical();
        test_priority();
        test_commit_block();
        test_reset();
        test_marker();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
